// File: rtl/imem_sync.sv
// imem_sync: synchronous-read instruction memory, loaded at boot over a
// valid/ready port, then serving IF fetches with one-cycle latency.
// Ports: clk, rst (sync, active high); loader ld_valid/ld_ready/ld_addr/
//   ld_data/ld_last/ld_count; fetch fetch_req/fetch_addr/fetch_stall/
//   fetch_flush -> fetch_valid/fetch_data/fetch_pc/fetch_fault; running.
// Option: define IMEM_FAULT_EN to flag misaligned/out-of-range fetches.
module imem_sync #(
   parameter int          DEPTH    = 256,
   parameter int          IDX_W    = $clog2(DEPTH),
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [IDX_W-1:0] ld_addr,
   input  logic [31:0]      ld_data,
   input  logic             ld_last,
   output logic [IDX_W:0]   ld_count,
   input  logic             fetch_req,
   input  logic [31:0]      fetch_addr,
   input  logic             fetch_stall,
   input  logic             fetch_flush,
   output logic             fetch_valid,
   output logic [31:0]      fetch_data,
   output logic [31:0]      fetch_pc,
   output logic             fetch_fault,
   output logic             running
);

   typedef enum logic {S_LOAD, S_RUN} state_t;

   localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

   state_t           state_q;
   logic             ld_ready_q;
   logic             running_q;
   logic [IDX_W:0]   ld_count_q, ld_count_d;

   logic [31:0]      mem [DEPTH];
   logic [31:0]      rd_q;

   logic             valid_q, valid_d;
   logic [31:0]      pc_q, pc_d;
   logic             fault_q, fault_d;
   // nop_q selects NOP_WORD over the RAM read register
   logic             nop_q, nop_d;

   logic             xfer;
   logic             accept;
   logic             addr_fault;
   logic [IDX_W-1:0] fetch_idx;

   assign xfer      = ld_valid & ld_ready_q;
   assign accept    = running_q & fetch_req & ~fetch_stall & ~fetch_flush;
   assign fetch_idx = fetch_addr[IDX_W+1:2];

`ifdef IMEM_FAULT_EN
   assign addr_fault = (fetch_addr[1:0] != 2'b00) |
                       (fetch_addr[31:IDX_W+2] != '0);
`else
   // Low and high address bits are don't-care: the index wraps.
   logic unused_addr;
   assign unused_addr = ^{fetch_addr[31:IDX_W+2], fetch_addr[1:0]};
   assign addr_fault  = 1'b0;
`endif

   // Load/run control; ld_ready and running are registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOAD;
         ld_ready_q <= 1'b1;
         running_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_LOAD: begin
               if (xfer && ld_last) begin
                  state_q    <= S_RUN;
                  ld_ready_q <= 1'b0;
                  running_q  <= 1'b1;
               end
            end
            S_RUN: begin
               state_q    <= S_RUN;
               ld_ready_q <= 1'b0;
               running_q  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      ld_count_d = ld_count_q;
      if (xfer && (ld_count_q != CNT_MAX)) begin
         ld_count_d = ld_count_q + CNT_ONE;
      end
   end

   // Single write port (loader) and single read port (fetch), no reset,
   // so the array maps onto block RAM and survives rst.
   always_ff @(posedge clk) begin
      if (xfer && !rst) begin
         mem[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rd_q <= mem[fetch_idx];
      end
   end

   // Flush beats stall; stall holds everything; idle drops valid only.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      nop_d   = nop_q;
      if (fetch_flush) begin
         valid_d = 1'b0;
         fault_d = 1'b0;
         nop_d   = 1'b1;
      end else if (fetch_stall) begin
         valid_d = valid_q;
      end else if (accept) begin
         valid_d = 1'b1;
         pc_d    = fetch_addr;
         fault_d = addr_fault;
         nop_d   = addr_fault;
      end else begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ld_count_q <= '0;
         valid_q    <= 1'b0;
         pc_q       <= '0;
         fault_q    <= 1'b0;
         nop_q      <= 1'b1;
      end else begin
         ld_count_q <= ld_count_d;
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         nop_q      <= nop_d;
      end
   end

   assign ld_ready    = ld_ready_q;
   assign ld_count    = ld_count_q;
   assign running     = running_q;
   assign fetch_valid = valid_q;
   assign fetch_pc    = pc_q;
   assign fetch_fault = fault_q;
   assign fetch_data  = nop_q ? NOP_WORD : rd_q;

endmodule
